// File: rtl/mem_local_master.sv
// mem_local_master: transfer initiator on the DDR2 controller half-rate local
// interface. One command (write or read, start word address, length) is split
// into bursts of at most MAX_BURST beats. Writes pull from a show-ahead source
// FIFO; reads are paced by the sink FIFO's free space and returned through a
// one-cycle register stage.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. cmd_valid/cmd_ready accept a command; local_write_req or
// local_read_req with local_ready accepts a beat or burst request. While a
// request is waiting for local_ready, every local_* output holds steady.
module mem_local_master #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 24,
  parameter int SIZE_W    = 3,
  parameter int MAX_BURST = 4,
  parameter int LEN_W     = 16,
  parameter int FIFO_W    = 11
) (
  input  logic                phy_clk,
  input  logic                reset,
  input  logic                local_init_done,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  output logic                err_stray,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [FIFO_W-1:0]   wr_used,
  output logic                wr_rdreq,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic [FIFO_W-1:0]   rd_free,
  output logic [ADDR_W-1:0]   local_address,
  output logic [SIZE_W-1:0]   local_size,
  output logic                local_burstbegin,
  output logic                local_write_req,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  output logic                local_read_req,
  input  logic                local_ready,
  input  logic [DATA_W-1:0]   local_rdata,
  input  logic                local_rdata_valid,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_WAIT  = 3'd1,
    S_WR_BEAT  = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_REQ   = 3'd4,
    S_RD_DRAIN = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [SIZE_W-1:0]   beat_q;
  logic [FIFO_W-1:0]   pending_q;
  logic [SIZE_W-1:0]   blen;
  logic [FIFO_W+1:0]   rd_need;
  logic                room_ok;
  logic                cmd_accept;
  logic                wr_accept;
  logic                last_beat;
  logic                rd_accept;

  // Current burst length; rem_q is constant for the whole burst.
  assign blen       = (rem_q < LEN_W'(MAX_BURST)) ? rem_q[SIZE_W-1:0] : SIZE_W'(MAX_BURST);
  // Sink must hold everything in flight plus this burst plus one word of usedw lag.
  assign rd_need    = {2'b00, pending_q} + (FIFO_W+2)'(blen) + (FIFO_W+2)'(1);
  assign room_ok    = ({2'b00, rd_free} >= rd_need);
  assign cmd_accept = (state == S_IDLE) & cmd_valid & local_init_done;
  assign wr_accept  = (state == S_WR_BEAT) & local_ready;
  assign last_beat  = wr_accept & (beat_q == blen - SIZE_W'(1));
  assign rd_accept  = (state == S_RD_REQ) & local_ready;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  // Next-state and local interface drive; outputs are idle-zero outside their states.
  always_comb begin
    state_nx         = state;
    cmd_ready        = 1'b0;
    done             = 1'b0;
    wr_rdreq         = 1'b0;
    local_address    = '0;
    local_size       = '0;
    local_burstbegin = 1'b0;
    local_write_req  = 1'b0;
    local_wdata      = '0;
    local_be         = '0;
    local_read_req   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = local_init_done;
        if (cmd_accept) begin
          if (cmd_len == '0)  state_nx = S_DONE;
          else if (cmd_write) state_nx = S_WR_WAIT;
          else                state_nx = S_RD_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (wr_used >= FIFO_W'(blen)) state_nx = S_WR_BEAT;
      end
      S_WR_BEAT: begin
        local_write_req  = 1'b1;
        local_wdata      = wr_data;
        local_be         = '1;
        local_address    = addr_q;
        local_size       = blen;
        local_burstbegin = (beat_q == '0);
        wr_rdreq         = local_ready;
        if (last_beat) state_nx = (rem_q == LEN_W'(blen)) ? S_DONE : S_WR_WAIT;
      end
      S_RD_WAIT: begin
        if (room_ok) state_nx = S_RD_REQ;
      end
      S_RD_REQ: begin
        local_read_req   = 1'b1;
        local_burstbegin = 1'b1;
        local_address    = addr_q;
        local_size       = blen;
        if (rd_accept) state_nx = (rem_q == LEN_W'(blen)) ? S_RD_DRAIN : S_RD_WAIT;
      end
      S_RD_DRAIN: begin
        if ((pending_q == '0) && !rd_valid) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, command progress, outstanding-read count and registered return path.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      pending_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err_stray <= 1'b0;
    end else begin
      state <= state_nx;
      if (cmd_accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
        beat_q <= '0;
      end
      if (wr_accept) beat_q <= last_beat ? '0 : beat_q + SIZE_W'(1);
      if (last_beat || rd_accept) begin
        rem_q  <= rem_q - LEN_W'(blen);
        addr_q <= addr_q + ADDR_W'(blen);
      end
      pending_q <= pending_q + (rd_accept ? FIFO_W'(blen) : FIFO_W'(0))
                             - (rd_valid  ? FIFO_W'(1)    : FIFO_W'(0));
      rd_valid  <= local_rdata_valid & (pending_q != '0);
      rd_data   <= local_rdata;
      if (local_rdata_valid && (pending_q == '0)) err_stray <= 1'b1;
    end
  end

endmodule
